// File: rtl/button_events.sv
// Push-button front end: two-flop synchroniser, debouncer and an event FSM.
// The FSM turns the debounced level into short-press, long-press and repeat pulses.
module button_events #(
    parameter int DEBOUNCE_CYCLES = 1 << 16,
    parameter int LONG_CYCLES     = 1 << 24,
    parameter int REPEAT_CYCLES   = 1 << 22,
    parameter int REPEAT_EN       = 1,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS,
    output logic LONG_PRESS,
    output logic REPEAT
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam int REP_W  = $clog2(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic              IDLE_PIN  = (ACTIVE_LOW != 0);
    localparam logic              REP_ON    = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        HELD = 2'd2
    } state_t;

    logic              sync1_reg;
    logic              sync2_reg;
    logic              raw;
    logic              level_reg;
    logic [DB_W-1:0]   db_cnt_reg;

    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
    logic              press_evt_reg, press_evt_next;
    logic              press_reg;
    logic              long_reg, long_next;
    logic              repeat_reg, repeat_next;

    assign raw = sync2_reg ^ IDLE_PIN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg  <= IDLE_PIN;
            sync2_reg  <= IDLE_PIN;
            level_reg  <= 1'b0;
            db_cnt_reg <= '0;
        end else begin
            sync1_reg <= BTN;
            sync2_reg <= sync1_reg;
            // Any sample that agrees with the current level restarts the count.
            if (raw == level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                level_reg  <= raw;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = hold_cnt_reg;
        rep_cnt_next   = rep_cnt_reg;
        press_evt_next = 1'b0;
        long_next      = 1'b0;
        repeat_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (level_reg) begin
                    state_next    = DOWN;
                    hold_cnt_next = '0;
                end
            end
            DOWN: begin
                // Release is tested first so it beats the long-press terminal count.
                if (!level_reg) begin
                    press_evt_next = 1'b1;
                    state_next     = IDLE;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    long_next    = 1'b1;
                    state_next   = HELD;
                    rep_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!level_reg) begin
                    state_next = IDLE;
                end else if (rep_cnt_reg == REP_LAST) begin
                    // The counter still rolls over with repeat disabled so it never wraps.
                    repeat_next  = REP_ON;
                    rep_cnt_next = '0;
                end else begin
                    rep_cnt_next = rep_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            hold_cnt_reg  <= '0;
            rep_cnt_reg   <= '0;
            press_evt_reg <= 1'b0;
            press_reg     <= 1'b0;
            long_reg      <= 1'b0;
            repeat_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            rep_cnt_reg   <= rep_cnt_next;
            press_evt_reg <= press_evt_next;
            // PRESS is retimed one cycle so it lands two edges after LEVEL falls.
            press_reg     <= press_evt_reg;
            long_reg      <= long_next;
            repeat_reg    <= repeat_next;
        end
    end

    assign LEVEL      = level_reg;
    assign PRESS      = press_reg;
    assign LONG_PRESS = long_reg;
    assign REPEAT     = repeat_reg;

endmodule
